// File: rtl/waveform_sequencer.sv
// -----------------------------------------------------------------------------
// waveform_sequencer
//
// Plays back a four-entry segment table. Each entry holds a waveform select
// (sel) and a duration counted in wave_en ticks. The prescaler produces one
// wave_en tick every div+1 cycles while running. A zero duration marks the
// end of the sequence.
//
// Optional feature: define WAVEFORM_SEQ_LOOP_EN to make the sequence restart
// from entry 0 at its end. In that mode done pulses alongside busy=1.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (also clears the table)
//   cfg_we   in   segment table write strobe
//   cfg_addr in   [1:0] table index to write
//   cfg_sel  in   [1:0] waveform select to store
//   cfg_dur  in   [DUR_W-1:0] duration to store (0 = end of sequence)
//   div      in   [DIV_W-1:0] prescale value, tick period div+1 cycles
//   start    in   level-sampled start request (honoured in IDLE only)
//   stop     in   abort request
//   sel      out  [1:0] waveform select of the active segment
//   wave_en  out  step enable to the waveform generator
//   seg_idx  out  [1:0] index of the active segment
//   busy     out  high while running
//   done     out  one-cycle end-of-sequence pulse
// -----------------------------------------------------------------------------
module waveform_sequencer #(
    parameter int DUR_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [1:0]       cfg_sel,
    input  logic [DUR_W-1:0] cfg_dur,
    input  logic [DIV_W-1:0] div,
    input  logic             start,
    input  logic             stop,
    output logic [1:0]       sel,
    output logic             wave_en,
    output logic [1:0]       seg_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       tbl_sel_r [0:3];
    logic [DUR_W-1:0] tbl_dur_r [0:3];
    logic [DIV_W-1:0] presc_r, presc_s;
    logic [DUR_W-1:0] rem_r, rem_s;
    logic [1:0]       sel_r, sel_s;
    logic [1:0]       idx_r, idx_s;
    logic             busy_r;
    logic             done_r, done_s;
    logic             tick_s;
    logic             seg_end_s;
    logic             last_seg_s;
    logic [1:0]       nidx_s;

    // Tick decode: compares against the live div so a div change applies
    // from the very next comparison.
    assign tick_s     = (state_r == ST_RUN) && (presc_r == div);
    assign seg_end_s  = tick_s && (rem_r == DUR_W'(1));
    assign nidx_s     = idx_r + 2'd1;
    assign last_seg_s = (idx_r == 2'd3) || (tbl_dur_r[nidx_s] == '0);

    // Segment table storage; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                tbl_sel_r[i] <= 2'b00;
                tbl_dur_r[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                tbl_sel_r[cfg_addr] <= cfg_sel;
                tbl_dur_r[cfg_addr] <= cfg_dur;
            end else begin
                tbl_sel_r[cfg_addr] <= tbl_sel_r[cfg_addr];
                tbl_dur_r[cfg_addr] <= tbl_dur_r[cfg_addr];
            end
        end
    end

    // Next-state, prescaler, segment bookkeeping and done pulse.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        rem_s   = rem_r;
        sel_s   = sel_r;
        idx_s   = idx_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (tbl_dur_r[0] == '0) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                        sel_s   = tbl_sel_r[0];
                        idx_s   = 2'd0;
                        rem_s   = tbl_dur_r[0];
                        presc_s = '0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    // Abort: sel and seg_idx keep their last values.
                    state_s = ST_IDLE;
                    presc_s = '0;
                end else begin
                    // A prescaler above a freshly lowered div wraps silently.
                    if (presc_r >= div) begin
                        presc_s = '0;
                    end else begin
                        presc_s = presc_r + DIV_W'(1);
                    end
                    if (tick_s) begin
                        rem_s = rem_r - DUR_W'(1);
                    end else begin
                        rem_s = rem_r;
                    end
                    if (seg_end_s) begin
                        if (!last_seg_s) begin
                            // Next segment loads on the same edge, no gap.
                            sel_s = tbl_sel_r[nidx_s];
                            idx_s = nidx_s;
                            rem_s = tbl_dur_r[nidx_s];
                        end else begin
`ifdef WAVEFORM_SEQ_LOOP_EN
                            done_s = 1'b1;
                            if (tbl_dur_r[0] == '0) begin
                                state_s = ST_DONE;
                            end else begin
                                sel_s = tbl_sel_r[0];
                                idx_s = 2'd0;
                                rem_s = tbl_dur_r[0];
                            end
`else
                            state_s = ST_DONE;
                            done_s  = 1'b1;
`endif
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                presc_s = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            presc_r <= '0;
            rem_r   <= '0;
            sel_r   <= 2'b00;
            idx_r   <= 2'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            presc_r <= presc_s;
            rem_r   <= rem_s;
            sel_r   <= sel_s;
            idx_r   <= idx_s;
            busy_r  <= (state_s == ST_RUN);
            done_r  <= done_s;
        end
    end

    assign sel     = sel_r;
    assign seg_idx = idx_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign wave_en = tick_s;

endmodule

// File: tb/tb_waveform_sequencer.sv
// -----------------------------------------------------------------------------
// tb_waveform_sequencer
//
// Table-driven bench: each record gives one cycle of inputs and the outputs
// expected after the following rising edge. Expected values are pushed to a
// scoreboard queue when the inputs are driven and popped on the next falling
// edge. A hand-written sequence then measures start-to-done latency and the
// number of wave_en ticks.
// -----------------------------------------------------------------------------
module tb_waveform_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_dur;
    logic [7:0]  div;
    logic        start;
    logic        stop;
    logic [1:0]  sel;
    logic        wave_en;
    logic [1:0]  seg_idx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    waveform_sequencer #(.DUR_W(16), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_sel(cfg_sel), .cfg_dur(cfg_dur), .div(div), .start(start),
        .stop(stop), .sel(sel), .wave_en(wave_en), .seg_idx(seg_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  addr;
        logic [1:0]  csel;
        logic [15:0] dur;
        logic [7:0]  dv;
        logic        st;
        logic        sp;
        logic [6:0]  exp;   // {sel, wave_en, seg_idx, busy, done}
    } vec_t;

    vec_t       vt[$];
    logic [6:0] sb[$];

    function automatic void add(input logic r, input logic we, input logic [1:0] a,
                                input logic [1:0] cs, input logic [15:0] d,
                                input logic [7:0] dv, input logic st, input logic sp,
                                input logic [1:0] es, input logic ew,
                                input logic [1:0] ei, input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.we = we; v.addr = a; v.csel = cs; v.dur = d; v.dv = dv;
        v.st = st; v.sp = sp; v.exp = {es, ew, ei, eb, ed};
        vt.push_back(v);
    endfunction

    task automatic run_table();
        logic [6:0] e;
        logic [6:0] got;
        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; cfg_we = vt[i].we; cfg_addr = vt[i].addr;
            cfg_sel = vt[i].csel; cfg_dur = vt[i].dur; div = vt[i].dv;
            start = vt[i].st; stop = vt[i].sp;
            sb.push_back(vt[i].exp);
            @(negedge clk);
            e   = sb.pop_front();
            got = {sel, wave_en, seg_idx, busy, done};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL vec%0d {sel,wen,idx,busy,done}: got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                         i, got[6:5], got[4], got[3:2], got[1], got[0],
                         e[6:5], e[4], e[3:2], e[1], e[0]);
            end
        end
        vt.delete();
    endtask

    initial begin
        int cycles;
        int ticks;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_sel = 2'd0;
        cfg_dur = 16'd0; div = 8'd0; start = 1'b0; stop = 1'b0;
        @(negedge clk);

        // reset overrides start and cfg_we
        add(1,1,0,3,16'd5,0,1,0, 0,0,0,0,0);
        add(0,0,0,0,16'd0,0,0,0, 0,0,0,0,0);
        // table {01,3},{10,2},{00,0}
        add(0,1,0,1,16'd3,0,0,0, 0,0,0,0,0);
        add(0,1,1,2,16'd2,0,0,0, 0,0,0,0,0);
        add(0,1,2,0,16'd0,0,0,0, 0,0,0,0,0);
        // two-segment run, div=0; start in RUN and DONE ignored
        add(0,0,0,0,16'd0,0,1,0, 1,1,0,1,0);
        add(0,0,0,0,16'd0,0,0,0, 1,1,0,1,0);
        add(0,0,0,0,16'd0,0,1,0, 1,1,0,1,0);
        add(0,0,0,0,16'd0,0,0,0, 2,1,1,1,0);
        add(0,0,0,0,16'd0,0,0,0, 2,1,1,1,0);
        add(0,0,0,0,16'd0,0,0,0, 2,0,1,0,1);
        add(0,0,0,0,16'd0,0,1,0, 2,0,1,0,0);
        add(0,0,0,0,16'd0,0,1,1, 2,0,1,0,0);
        add(0,0,0,0,16'd0,0,0,0, 2,0,1,0,0);
        // rewrite entry1 to {11,4} while entry0 runs
        add(0,0,0,0,16'd0,0,1,0, 1,1,0,1,0);
        add(0,1,1,3,16'd4,0,0,0, 1,1,0,1,0);
        add(0,0,0,0,16'd0,0,0,0, 1,1,0,1,0);
        for (int k = 0; k < 4; k++) add(0,0,0,0,16'd0,0,0,0, 3,1,1,1,0);
        add(0,0,0,0,16'd0,0,0,0, 3,0,1,0,1);
        add(0,0,0,0,16'd0,0,0,0, 3,0,1,0,0);
        // div=3, single entry {11,2}: ticks at RUN cycles 4 and 8
        add(0,1,0,3,16'd2,3,0,0, 3,0,1,0,0);
        add(0,1,1,0,16'd0,3,0,0, 3,0,1,0,0);
        add(0,0,0,0,16'd0,3,1,0, 3,0,0,1,0);
        add(0,0,0,0,16'd0,3,0,0, 3,0,0,1,0);
        add(0,0,0,0,16'd0,3,0,0, 3,0,0,1,0);
        add(0,0,0,0,16'd0,3,0,0, 3,1,0,1,0);
        for (int k = 0; k < 3; k++) add(0,0,0,0,16'd0,3,0,0, 3,0,0,1,0);
        add(0,0,0,0,16'd0,3,0,0, 3,1,0,1,0);
        add(0,0,0,0,16'd0,3,0,0, 3,0,0,0,1);
        add(0,0,0,0,16'd0,3,0,0, 3,0,0,0,0);
        // div lowered 3->1 with prescaler at 2: silent wrap, then ticks
        add(0,0,0,0,16'd0,3,1,0, 3,0,0,1,0);
        add(0,0,0,0,16'd0,3,0,0, 3,0,0,1,0);
        add(0,0,0,0,16'd0,3,0,0, 3,0,0,1,0);
        add(0,0,0,0,16'd0,1,0,0, 3,0,0,1,0);
        add(0,0,0,0,16'd0,1,0,0, 3,1,0,1,0);
        add(0,0,0,0,16'd0,1,0,0, 3,0,0,1,0);
        add(0,0,0,0,16'd0,1,0,0, 3,1,0,1,0);
        add(0,0,0,0,16'd0,1,0,0, 3,0,0,0,1);
        add(0,0,0,0,16'd0,0,0,0, 3,0,0,0,0);
        // stop in 2nd RUN cycle of {01,5}
        add(0,1,0,1,16'd5,0,0,0, 3,0,0,0,0);
        add(0,0,0,0,16'd0,0,1,0, 1,1,0,1,0);
        add(0,0,0,0,16'd0,0,0,0, 1,1,0,1,0);
        add(0,0,0,0,16'd0,0,0,1, 1,0,0,0,0);
        add(0,0,0,0,16'd0,0,0,0, 1,0,0,0,0);
        add(0,0,0,0,16'd0,0,0,0, 1,0,0,0,0);
        // reset mid-RUN, then start with cleared table goes straight to DONE
        add(0,0,0,0,16'd0,0,1,0, 1,1,0,1,0);
        add(1,1,0,2,16'd7,0,1,0, 0,0,0,0,0);
        add(0,0,0,0,16'd0,0,1,0, 0,0,0,0,1);
        add(0,0,0,0,16'd0,0,0,0, 0,0,0,0,0);
`ifdef WAVEFORM_SEQ_LOOP_EN
        // looping {10,1},{01,1}: done every second cycle, busy held
        add(0,1,0,2,16'd1,0,0,0, 0,0,0,0,0);
        add(0,1,1,1,16'd1,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,16'd0,0,1,0, 2,1,0,1,0);
        add(0,0,0,0,16'd0,0,0,0, 1,1,1,1,0);
        add(0,0,0,0,16'd0,0,0,0, 2,1,0,1,1);
        add(0,0,0,0,16'd0,0,0,0, 1,1,1,1,0);
        add(0,0,0,0,16'd0,0,0,0, 2,1,0,1,1);
        add(0,0,0,0,16'd0,0,0,1, 2,0,0,0,0);
`endif
        run_table();

        // Hand-written: {10,3} with div=2 gives done 10 cycles after start
        // and exactly three wave_en ticks on the way.
        rst = 1'b0; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_sel = 2'd2; cfg_dur = 16'd3;
        div = 8'd2; start = 1'b0; stop = 1'b0;
        @(negedge clk);
        cfg_addr = 2'd1; cfg_sel = 2'd0; cfg_dur = 16'd0;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b1;
        cycles = 0; ticks = 0;
        while (cycles < 100) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (wave_en) ticks++;
            if (done) break;
        end
        total++;
        if (cycles != 10) begin
            bad++;
            $display("FAIL latency: got %0d cycles want 10", cycles);
        end
        total++;
        if (ticks != 3) begin
            bad++;
            $display("FAIL tick_count: got %0d want 3", ticks);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after: busy got %b want 0", busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
